// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and defaults for the multiply/divide unit
package mips_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - 2*WIDTH accumulator with one shift-add or restoring-divide step per cycle
module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               ResetL,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply: upper half accumulates, the multiplier drains out of the low end.
  // Divide: remainder in the upper half, quotient bits shift in at the low end.
  always_comb begin
    mcand      = acc_q[0] ? opb_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    div_part   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = div_part - {1'b0, opb_q};
    div_borrow = div_part < {1'b0, opb_q};
    if (!mode) begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (div_borrow) begin
      acc_next = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      acc_q <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc_q <= {{WIDTH{1'b0}}, op_a};
      opb_q <= op_b;
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/DIV unit owning HI/LO, with FSM, counter and sign fixup
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNTW  = 5
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             Start,
  input  logic [2:0]       MDCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  md_state_e          state, state_next;
  logic [CNTW-1:0]    cnt;
  logic               accept_arith, accept_mt;
  logic               dp_load, dp_step, fix_en;
  logic               op_signed;
  logic               op_div, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept_arith = (state == MD_IDLE) && Start && !MDCtrl[2];
  assign accept_mt    = (state == MD_IDLE) && Start &&
                        ((MDCtrl == MD_MTHI) || (MDCtrl == MD_MTLO));
  assign op_signed    = !MDCtrl[0];

  // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
  assign mag_a = (op_signed && BusA[WIDTH-1]) ? -BusA : BusA;
  assign mag_b = (op_signed && BusB[WIDTH-1]) ? -BusB : BusB;

  always_ff @(posedge Clk) begin
    if (!ResetL) state <= MD_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (accept_arith) state_next = MD_RUN;
      MD_RUN:  if (cnt == CNT_LAST) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state != MD_IDLE);
    dp_load = accept_arith;
    dp_step = (state == MD_RUN);
    fix_en  = (state == MD_FIX);
  end

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      cnt    <= '0;
      op_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
    end else if (dp_load) begin
      cnt    <= '0;
      op_div <= MDCtrl[1];
      a_neg  <= op_signed && BusA[WIDTH-1];
      b_neg  <= op_signed && BusB[WIDTH-1];
      b_zero <= (BusB == '0);
    end else if (dp_step) begin
      cnt <= cnt + 1'b1;
    end
  end

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .Clk    (Clk),
    .ResetL (ResetL),
    .load   (dp_load),
    .step   (dp_step),
    .mode   (op_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (acc)
  );

  // Remainder follows the dividend's sign; divide-by-zero keeps the all-ones quotient.
  always_comb begin
    prod   = (a_neg ^ b_neg) ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_div) begin
      fix_hi = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (b_zero)           fix_lo = {WIDTH{1'b1}};
      else if (a_neg ^ b_neg) fix_lo = -acc[WIDTH-1:0];
      else                  fix_lo = acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      Hi   <= '0;
      Lo   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= fix_en || accept_mt;
      if (fix_en) begin
        Hi <= fix_hi;
        Lo <= fix_lo;
      end else if (accept_mt) begin
        if (MDCtrl == MD_MTHI) Hi <= BusA;
        else                   Lo <= BusA;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         ResetL, Start;
  logic [2:0]   MDCtrl;
  logic [W-1:0] BusA, BusB;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi, exp_lo;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(W), .CNTW(5)) dut (
    .Clk    (Clk),
    .ResetL (ResetL),
    .Start  (Start),
    .MDCtrl (MDCtrl),
    .BusA   (BusA),
    .BusB   (BusB),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural HI/LO effect of one operation, from plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    case (op)
      MD_MULT: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        {exp_hi, exp_lo} = sp;
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {exp_hi, exp_lo} = up;
      end
      MD_DIV: begin
        if (b == 0) begin
          exp_lo = '1; exp_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000; exp_hi = 0;
        end else begin
          exp_lo = $signed(a) / $signed(b);
          exp_hi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == 0) begin
          exp_lo = '1; exp_hi = a;
        end else begin
          exp_lo = a / b; exp_hi = a % b;
        end
      end
      MD_MTHI: exp_hi = a;
      MD_MTLO: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue an arithmetic op, optionally poke Start at cycles g1/g2 of the run; ends in the Done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int g1, input int g2);
    logic [W-1:0] old_hi, old_lo;
    int n, busy_n;
    bit held;
    old_hi = exp_hi; old_lo = exp_lo;
    n = 0; busy_n = 0; held = 1'b1;
    Start = 1'b1; MDCtrl = op; BusA = a; BusB = b;
    tick;
    Start = 1'b0; BusA = $urandom; BusB = $urandom;
    model(op, a, b);
    while (!Done && n < 100) begin
      if (Busy) busy_n++;
      held = held && (Hi === old_hi) && (Lo === old_lo);
      Start  = (n == g1) || (n == g2);
      MDCtrl = (n == g1) ? MD_MTHI : MD_DIVU;
      tick;
      Start = 1'b0;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'd33);
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, ".busy_in_done"}, 64'(Busy), 64'd0);
    check({tag, ".hold"}, 64'(held), 64'd1);
    check({tag, ".hi"}, 64'(Hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(Lo), 64'(exp_lo));
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    Start = 1'b1; MDCtrl = op; BusA = a; BusB = $urandom;
    tick;
    Start = 1'b0;
    model(op, a, 0);
    check({tag, ".done"}, 64'(Done), 64'd1);
    check({tag, ".busy"}, 64'(Busy), 64'd0);
    check({tag, ".hi"}, 64'(Hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(Lo), 64'(exp_lo));
    tick;
    check({tag, ".done_pulse"}, 64'(Done), 64'd0);
  endtask

  task automatic run_noop(input string tag, input logic [2:0] op);
    Start = 1'b1; MDCtrl = op; BusA = $urandom; BusB = $urandom;
    tick;
    Start = 1'b0;
    check({tag, ".done"}, 64'(Done), 64'd0);
    check({tag, ".busy"}, 64'(Busy), 64'd0);
    check({tag, ".hilo"}, {Hi, Lo}, {exp_hi, exp_lo});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    ResetL = 1'b0; Start = 1'b0; MDCtrl = 3'b000; BusA = '0; BusB = '0;
    repeat (2) tick;
    check("reset.busy", 64'(Busy), 64'd0);
    check("reset.done", 64'(Done), 64'd0);
    check("reset.hilo", {Hi, Lo}, 64'd0);
    ResetL = 1'b1;
    exp_hi = '0; exp_lo = '0;
    tick;

    run_op("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, -1, -1);
    check("mult_neg3x5.const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    tick;
    check("mult_neg3x5.done_pulse", 64'(Done), 64'd0);

    run_op("multu_ones", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("multu_ones.const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_ones", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("mult_ones.const", {Hi, Lo}, 64'h0000_0000_0000_0001);
    run_op("div_neg7by2", MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1);
    check("div_neg7by2.const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7by0", MD_DIVU, 32'd7, 32'd0, -1, -1);
    check("divu_7by0.const", {Hi, Lo}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_minby_neg1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    check("div_minby_neg1.const", {Hi, Lo}, 64'h0000_0000_8000_0000);
    run_op("div_neg5by0", MD_DIV, 32'hFFFF_FFFB, 32'd0, -1, -1);
    check("div_neg5by0.const", {Hi, Lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    tick;

    run_mt("mthi", MD_MTHI, 32'h1234_5678);
    run_op("mult_ignored_starts", MD_MULT, 32'd2, 32'd3, 5, 10);
    check("mult_ignored_starts.const", {Hi, Lo}, 64'd6);
    tick;

    Start = 1'b1; MDCtrl = MD_DIV; BusA = 32'd100; BusB = 32'd7;
    tick;
    Start = 1'b0;
    repeat (11) tick;
    ResetL = 1'b0;
    tick;
    check("reset_mid.busy", 64'(Busy), 64'd0);
    check("reset_mid.done", 64'(Done), 64'd0);
    check("reset_mid.hilo", {Hi, Lo}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    ResetL = 1'b1;
    run_op("multu_after_reset", MD_MULTU, 32'd4, 32'd4, -1, -1);
    check("multu_after_reset.const", 64'(Lo), 64'd16);

    run_op("b2b_multu_3x3", MD_MULTU, 32'd3, 32'd3, -1, -1);
    check("b2b_multu_3x3.const", 64'(Lo), 64'd9);
    run_noop("noop110", 3'b110);
    run_noop("noop111", 3'b111);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op < 3'd4)      run_op("rand_arith", op, pick(), pick(), -1, -1);
      else if (op < 3'd6) run_mt("rand_mt", op, $urandom);
      else                run_noop("rand_noop", op);
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
